// File: rtl/mem_op_queue.sv
// mem_op_queue: in-order load/store queue with CDB operand capture, issuing only from the head
module mem_op_queue #(
    parameter int DEPTH = 8,
    parameter int ROB_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    input  logic                     disp_is_store,
    input  logic [2:0]               disp_funct3,
    input  logic [31:0]              disp_imm,
    input  logic [ROB_W-1:0]         disp_rob,
    input  logic                     disp_rs1_rdy,
    input  logic [ROB_W-1:0]         disp_rs1_tag,
    input  logic [31:0]              disp_rs1_data,
    input  logic                     disp_rs2_rdy,
    input  logic [ROB_W-1:0]         disp_rs2_tag,
    input  logic [31:0]              disp_rs2_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     cdb_valid,
    input  logic [ROB_W-1:0]         cdb_rob,
    input  logic [31:0]              cdb_data,
    input  logic [ROB_W-1:0]         rob_head,
    output logic                     ld_issue,
    input  logic                     ld_busy,
    output logic                     st_issue,
    input  logic                     st_busy,
    output logic [2:0]               iss_funct3,
    output logic [31:0]              iss_rs1_data,
    output logic [31:0]              iss_rs2_data,
    output logic [31:0]              iss_imm,
    output logic [ROB_W-1:0]         iss_rob
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] vld_q, vld_d, st_q, st_d, r1_rdy_q, r1_rdy_d, r2_rdy_q, r2_rdy_d;
    logic [2:0]       f3_q     [DEPTH];
    logic [2:0]       f3_d     [DEPTH];
    logic [31:0]      imm_q    [DEPTH];
    logic [31:0]      imm_d    [DEPTH];
    logic [ROB_W-1:0] rob_q    [DEPTH];
    logic [ROB_W-1:0] rob_d    [DEPTH];
    logic [ROB_W-1:0] r1_tag_q [DEPTH];
    logic [ROB_W-1:0] r1_tag_d [DEPTH];
    logic [ROB_W-1:0] r2_tag_q [DEPTH];
    logic [ROB_W-1:0] r2_tag_d [DEPTH];
    logic [31:0]      r1_q     [DEPTH];
    logic [31:0]      r1_d     [DEPTH];
    logic [31:0]      r2_q     [DEPTH];
    logic [31:0]      r2_d     [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic             d_r1_rdy, d_r2_rdy;
    logic [31:0]      d_r1, d_r2;

    // Source capture at dispatch, including a same-cycle CDB hit; loads never wait on rs2
    always_comb begin
        d_r1_rdy = disp_rs1_rdy || (cdb_valid && cdb_rob == disp_rs1_tag);
        d_r1     = disp_rs1_rdy ? disp_rs1_data : cdb_data;
        d_r2_rdy = !disp_is_store || disp_rs2_rdy || (cdb_valid && cdb_rob == disp_rs2_tag);
        d_r2     = (disp_is_store && !disp_rs2_rdy) ? cdb_data : disp_rs2_data;
    end

    // Head issue decision; operands come only from already-latched entry state
    always_comb begin
        ld_issue     = !rst && !flush && vld_q[head_q] && !st_q[head_q] && r1_rdy_q[head_q] && !ld_busy;
        st_issue     = !rst && !flush && vld_q[head_q] && st_q[head_q] && r1_rdy_q[head_q]
                       && r2_rdy_q[head_q] && rob_head == rob_q[head_q] && !st_busy;
        iss_funct3   = f3_q[head_q];
        iss_rs1_data = r1_q[head_q];
        iss_rs2_data = r2_q[head_q];
        iss_imm      = imm_q[head_q];
        iss_rob      = rob_q[head_q];
        full         = count_q == CW'(DEPTH);
        count        = count_q;
        push         = disp_valid && !full && !flush;
        pop          = ld_issue || st_issue;
    end

    // Next state: CDB wakeup of waiting entries, head pop, tail write, then flush override
    always_comb begin
        vld_d    = vld_q;
        st_d     = st_q;
        r1_rdy_d = r1_rdy_q;
        r2_rdy_d = r2_rdy_q;
        f3_d     = f3_q;
        imm_d    = imm_q;
        rob_d    = rob_q;
        r1_tag_d = r1_tag_q;
        r2_tag_d = r2_tag_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !r1_rdy_q[i] && cdb_valid && cdb_rob == r1_tag_q[i]) begin
                r1_rdy_d[i] = 1'b1;
                r1_d[i]     = cdb_data;
            end
            if (vld_q[i] && !r2_rdy_q[i] && cdb_valid && cdb_rob == r2_tag_q[i]) begin
                r2_rdy_d[i] = 1'b1;
                r2_d[i]     = cdb_data;
            end
        end
        if (pop) vld_d[head_q] = 1'b0;
        if (push) begin
            vld_d[tail_q]    = 1'b1;
            st_d[tail_q]     = disp_is_store;
            f3_d[tail_q]     = disp_funct3;
            imm_d[tail_q]    = disp_imm;
            rob_d[tail_q]    = disp_rob;
            r1_tag_d[tail_q] = disp_rs1_tag;
            r2_tag_d[tail_q] = disp_rs2_tag;
            r1_rdy_d[tail_q] = d_r1_rdy;
            r2_rdy_d[tail_q] = d_r2_rdy;
            r1_d[tail_q]     = d_r1;
            r2_d[tail_q]     = d_r2;
        end
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            vld_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Control state: valid bits, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload; meaningless while the valid bit is clear, so it needs no reset
    always_ff @(posedge clk) begin
        st_q     <= st_d;
        r1_rdy_q <= r1_rdy_d;
        r2_rdy_q <= r2_rdy_d;
        f3_q     <= f3_d;
        imm_q    <= imm_d;
        rob_q    <= rob_d;
        r1_tag_q <= r1_tag_d;
        r2_tag_q <= r2_tag_d;
        r1_q     <= r1_d;
        r2_q     <= r2_d;
    end
endmodule

// File: tb/tb_mem_op_queue.sv
// tb_mem_op_queue: scoreboard bench for the in-order memory op queue
module tb_mem_op_queue;
    localparam int DEPTH = 8;
    localparam int ROB_W = 5;

    logic clk, rst, flush;
    logic disp_valid, disp_is_store, disp_rs1_rdy, disp_rs2_rdy;
    logic [2:0] disp_funct3;
    logic [31:0] disp_imm, disp_rs1_data, disp_rs2_data, cdb_data;
    logic [ROB_W-1:0] disp_rob, disp_rs1_tag, disp_rs2_tag, cdb_rob, rob_head, iss_rob;
    logic full, cdb_valid, ld_issue, ld_busy, st_issue, st_busy;
    logic [$clog2(DEPTH):0] count;
    logic [2:0] iss_funct3;
    logic [31:0] iss_rs1_data, iss_rs2_data, iss_imm;

    typedef struct {
        logic             st;
        logic [2:0]       f3;
        logic [ROB_W-1:0] rob;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [31:0]      imm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int n_vec = 0;
    int n_err = 0;

    mem_op_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_funct3(disp_funct3),
        .disp_imm(disp_imm), .disp_rob(disp_rob),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_data(disp_rs1_data),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_data(disp_rs2_data),
        .full(full), .count(count),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data), .rob_head(rob_head),
        .ld_issue(ld_issue), .ld_busy(ld_busy), .st_issue(st_issue), .st_busy(st_busy),
        .iss_funct3(iss_funct3), .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
        .iss_imm(iss_imm), .iss_rob(iss_rob)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                        input logic [ROB_W-1:0] rob, input logic r1rdy, input logic [ROB_W-1:0] r1tag,
                        input logic [31:0] r1d, input logic r2rdy, input logic [ROB_W-1:0] r2tag,
                        input logic [31:0] r2d);
        disp_valid    = 1;
        disp_is_store = st;
        disp_funct3   = f3;
        disp_imm      = imm;
        disp_rob      = rob;
        disp_rs1_rdy  = r1rdy;
        disp_rs1_tag  = r1tag;
        disp_rs1_data = r1d;
        disp_rs2_rdy  = r2rdy;
        disp_rs2_tag  = r2tag;
        disp_rs2_data = r2d;
    endtask

    task automatic expect_iss(input logic st, input logic [2:0] f3, input logic [ROB_W-1:0] rob,
                              input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        e.st = st; e.f3 = f3; e.rob = rob; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((count != 0 || sb.size() != 0) && k < budget) begin
            cyc();
            k++;
        end
        check("drain_count", count, 0);
        check("drain_sb", sb.size(), 0);
    endtask

    // Scoreboard: every issue strobe must match the oldest outstanding dispatch
    always @(negedge clk) begin
        if (!rst) begin
            check("one_strobe", ld_issue & st_issue, 0);
            if (ld_issue || st_issue) begin
                if (sb.size() == 0) check("unexp_issue", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("iss_kind", st_issue, mon_e.st);
                    check("iss_rob", iss_rob, mon_e.rob);
                    check("iss_f3", iss_funct3, mon_e.f3);
                    check("iss_rs1", iss_rs1_data, mon_e.rs1);
                    check("iss_imm", iss_imm, mon_e.imm);
                    if (mon_e.st) check("iss_rs2", iss_rs2_data, mon_e.rs2);
                end
            end
        end
    end

    initial begin
        rst = 1; flush = 0; disp_valid = 0; disp_is_store = 0; disp_funct3 = 0; disp_imm = 0;
        disp_rob = 0; disp_rs1_rdy = 0; disp_rs1_tag = 0; disp_rs1_data = 0; disp_rs2_rdy = 0;
        disp_rs2_tag = 0; disp_rs2_data = 0; cdb_valid = 0; cdb_rob = 0; cdb_data = 0;
        rob_head = 0; ld_busy = 0; st_busy = 0;
        repeat (2) cyc();
        rst = 0;
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_ld", ld_issue, 0);
        check("rst_st", st_issue, 0);

        // ready load into empty queue issues one cycle after dispatch
        cyc(); disp(0, 3'b010, 32'd4, 5'd3, 1, 0, 32'h1000, 0, 0, 0);
        expect_iss(0, 3'b010, 5'd3, 32'h1000, 0, 32'd4);
        @(negedge clk); check("t1_empty_ld", ld_issue, 0);
        cyc(); disp_valid = 0;
        @(negedge clk); check("t1_ld", ld_issue, 1); check("t1_cnt1", count, 1);
        cyc();
        @(negedge clk); check("t1_cnt0", count, 0); check("t1_ld_off", ld_issue, 0);

        // store waits for rs2 via CDB and then for ROB head
        cyc(); rob_head = 5'd4; disp(1, 3'b010, 32'd8, 5'd5, 1, 0, 32'h2000, 0, 5'd2, 0);
        expect_iss(1, 3'b010, 5'd5, 32'h2000, 32'hDEAD, 32'd8);
        cyc(); disp_valid = 0;
        @(negedge clk); check("t2_wait_rs2", st_issue, 0); check("t2_cnt", count, 1);
        cyc(); cdb_valid = 1; cdb_rob = 5'd2; cdb_data = 32'hDEAD;
        @(negedge clk); check("t2_cdb_cycle", st_issue, 0);
        cyc(); cdb_valid = 0;
        @(negedge clk); check("t2_not_head", st_issue, 0);
        cyc(); rob_head = 5'd5;
        @(negedge clk); check("t2_st", st_issue, 1);
        cyc();
        @(negedge clk); check("t2_cnt0", count, 0);

        // dispatch-time CDB bypass
        cyc(); disp(0, 3'b100, 32'd0, 5'd6, 0, 5'd7, 0, 0, 0, 0);
        cdb_valid = 1; cdb_rob = 5'd7; cdb_data = 32'h20;
        expect_iss(0, 3'b100, 5'd6, 32'h20, 0, 32'd0);
        cyc(); disp_valid = 0; cdb_valid = 0;
        @(negedge clk); check("t3_ld", ld_issue, 1);
        cyc();
        @(negedge clk); check("t3_cnt0", count, 0);

        // fill to full, drop ninth, drain with wrap and a post-wrap dispatch
        ld_busy = 1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(); disp(0, 3'b010, 32'(i), 5'(8 + i), 1, 0, 32'h100 * i, 0, 0, 0);
            expect_iss(0, 3'b010, 5'(8 + i), 32'h100 * i, 0, 32'(i));
        end
        cyc(); disp(0, 3'b010, 32'd99, 5'd20, 1, 0, 32'hBAD, 0, 0, 0);
        @(negedge clk); check("t4_full", full, 1); check("t4_cnt8", count, 8);
        cyc(); disp_valid = 0; ld_busy = 0;
        @(negedge clk); check("t4_drop_cnt", count, 8); check("t4_ld", ld_issue, 1);
        cyc(); disp(0, 3'b000, 32'd21, 5'd21, 1, 0, 32'h2121, 0, 0, 0);
        expect_iss(0, 3'b000, 5'd21, 32'h2121, 0, 32'd21);
        @(negedge clk); check("t4_not_full", full, 0); check("t4_cnt7", count, 7);
        cyc(); disp_valid = 0;
        drain(40);

        // blocked head load keeps a ready store behind it
        ld_busy = 1;
        cyc(); disp(0, 3'b000, 32'hFFFF_FFFC, 5'd22, 1, 0, 32'h30, 0, 0, 0);
        expect_iss(0, 3'b000, 5'd22, 32'h30, 0, 32'hFFFF_FFFC);
        cyc(); rob_head = 5'd23; disp(1, 3'b001, 32'd2, 5'd23, 1, 0, 32'h40, 1, 0, 32'h55);
        expect_iss(1, 3'b001, 5'd23, 32'h40, 32'h55, 32'd2);
        cyc(); disp_valid = 0;
        @(negedge clk); check("t5_ld0", ld_issue, 0); check("t5_st0", st_issue, 0); check("t5_cnt2", count, 2);
        cyc();
        @(negedge clk); check("t5_no_bypass", st_issue, 0);
        cyc(); ld_busy = 0;
        @(negedge clk); check("t5_ld_first", ld_issue, 1); check("t5_st_wait", st_issue, 0);
        cyc();
        @(negedge clk); check("t5_st", st_issue, 1);
        cyc();
        @(negedge clk); check("t5_cnt0", count, 0);

        // flush with a concurrent dispatch empties the queue
        ld_busy = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(); disp(0, 3'b010, 32'd0, 5'(24 + i), 1, 0, 32'h77, 0, 0, 0);
        end
        cyc(); flush = 1; ld_busy = 0; disp(0, 3'b010, 32'd0, 5'd27, 1, 0, 32'h88, 0, 0, 0);
        @(negedge clk); check("t6_flush_ld", ld_issue, 0); check("t6_cnt3", count, 3);
        cyc(); flush = 0; disp_valid = 0;
        @(negedge clk);
        check("t6_cnt0", count, 0); check("t6_full", full, 0);
        check("t6_ld", ld_issue, 0); check("t6_st", st_issue, 0);
        repeat (3) cyc();
        cyc(); disp(0, 3'b101, 32'd12, 5'd28, 1, 0, 32'h9000, 0, 0, 0);
        expect_iss(0, 3'b101, 5'd28, 32'h9000, 0, 32'd12);
        cyc(); disp_valid = 0;
        @(negedge clk); check("t6_post_ld", ld_issue, 1);
        cyc();
        @(negedge clk);
        check("end_cnt", count, 0);
        check("end_sb", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
